// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult_pkg;

   // Control FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of a counter that must hold the values 0..n inclusive.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/shift_add_dp.sv
// Shift-and-add datapath: ACC/Q/M registers plus the add/subtract/shift step.
// One partial product is folded in per step strobe. With a signed operation,
// the last step subtracts M because the multiplier MSB has negative weight.
module shift_add_dp
   import mult_pkg::*;
#(
   parameter int WIDTH_A = 8,
   parameter int WIDTH_B = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic                       step,
   input  logic                       last,
   input  logic                       sgn_in,
   input  logic [WIDTH_A-1:0]         a,
   input  logic [WIDTH_B-1:0]         b,
   output logic [WIDTH_A+WIDTH_B-1:0] result
);

   localparam int AW = WIDTH_A + 1;
   localparam int SW = WIDTH_A + 2;

   logic [AW-1:0]      acc;
   logic [AW-1:0]      m;
   logic [WIDTH_B-1:0] q;
   logic               sgn_q;
   logic [SW-1:0]      acc_x;
   logic [SW-1:0]      m_x;
   logic [SW-1:0]      s;

   // Extend ACC and M by one bit so the top bit of S is the sign (signed)
   // or the carry (unsigned), then form this step's partial sum.
   always_comb begin
      acc_x = {(sgn_q & acc[AW-1]), acc};
      m_x   = {(sgn_q & m[AW-1]), m};
      s     = acc_x;
      if (q[0]) begin
         if (last && sgn_q) s = acc_x - m_x;
         else               s = acc_x + m_x;
      end
   end

   // Load operands on accept; on each step shift {S,Q} right by one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         m     <= '0;
         q     <= '0;
         sgn_q <= 1'b0;
      end else if (load) begin
         acc   <= '0;
         q     <= b;
         m     <= sgn_in ? {a[WIDTH_A-1], a} : {1'b0, a};
         sgn_q <= sgn_in;
      end else if (step) begin
         acc <= s[SW-1:1];
         q   <= {s[0], q[WIDTH_B-1:1]};
      end
   end

   assign result = {acc[WIDTH_A-1:0], q};

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier with start/done handshake and a
// per-operation signed/unsigned mode. WIDTH_B steps per operation followed by
// one cycle (count == WIDTH_B) that loads the product and enters DONE.
// Handshake: start is sampled only while busy=0 (IDLE or DONE); done pulses for
// one cycle in DONE and product is held from that pulse to the next one.
module shift_add_mult
   import mult_pkg::*;
#(
   parameter int WIDTH_A = 8,
   parameter int WIDTH_B = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       sgn,
   input  logic [WIDTH_A-1:0]         a,
   input  logic [WIDTH_B-1:0]         b,
   output logic                       busy,
   output logic                       done,
   output logic [WIDTH_A+WIDTH_B-1:0] product
);

   localparam int CW = cnt_width(WIDTH_B);

   state_t                       state, state_n;
   logic [CW-1:0]                count;
   logic                         load, step, last, finish;
   logic [WIDTH_A+WIDTH_B-1:0]   result;

   shift_add_dp #(
      .WIDTH_A (WIDTH_A),
      .WIDTH_B (WIDTH_B)
   ) u_dp (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .last   (last),
      .sgn_in (sgn),
      .a      (a),
      .b      (b),
      .result (result)
   );

   // Next-state and datapath strobes.
   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      last    = 1'b0;
      finish  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            if (count == CW'(WIDTH_B)) begin
               finish  = 1'b1;
               state_n = DONE;
            end else begin
               step = 1'b1;
               last = (count == CW'(WIDTH_B - 1));
            end
         end
         DONE: begin
            if (start) begin
               load    = 1'b1;
               state_n = RUN;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, step counter and result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         product <= '0;
      end else begin
         state <= state_n;
         if (load)      count <= '0;
         else if (step) count <= count + 1'b1;
         if (finish)    product <= result;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and small random checks for shift_add_mult at 8x8, 12x5 and 13x7.
module tb_shift_add_mult;

  logic clk;
  logic rst;

  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  logic        start12, sgn12, busy12, done12;
  logic [11:0] a12;
  logic [4:0]  b12;
  logic [16:0] product12;

  logic        start13, sgn13, busy13, done13;
  logic [12:0] a13;
  logic [6:0]  b13;
  logic [19:0] product13;

  int n_cmp;
  int n_bad;

  logic [15:0] hold8;
  logic [19:0] hold13;

  shift_add_mult #(.WIDTH_A(8), .WIDTH_B(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  shift_add_mult #(.WIDTH_A(12), .WIDTH_B(5)) u_dut12 (
    .clk(clk), .rst(rst), .start(start12), .sgn(sgn12), .a(a12), .b(b12),
    .busy(busy12), .done(done12), .product(product12)
  );

  shift_add_mult #(.WIDTH_A(13), .WIDTH_B(7)) u_dut13 (
    .clk(clk), .rst(rst), .start(start13), .sgn(sgn13), .a(a13), .b(b13),
    .busy(busy13), .done(done13), .product(product13)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // product must stay put between done pulses
  always @(negedge clk) begin
    if (rst) begin
      hold8  <= '0;
      hold13 <= '0;
    end else begin
      if (done8) hold8 <= product8;
      else       check("hold8", 64'(product8), 64'(hold8));
      if (done13) hold13 <= product13;
      else        check("hold13", 64'(product13), 64'(hold13));
    end
  end

  function automatic int wa_of(input int which);
    return (which == 0) ? 8 : (which == 1) ? 12 : 13;
  endfunction

  function automatic int wb_of(input int which);
    return (which == 0) ? 8 : (which == 1) ? 5 : 7;
  endfunction

  function automatic logic sel_done(input int which);
    return (which == 0) ? done8 : (which == 1) ? done12 : done13;
  endfunction

  function automatic logic sel_busy(input int which);
    return (which == 0) ? busy8 : (which == 1) ? busy12 : busy13;
  endfunction

  function automatic logic [63:0] sel_prod(input int which);
    return (which == 0) ? 64'(product8) : (which == 1) ? 64'(product12) : 64'(product13);
  endfunction

  // reference model: exact product truncated to wa+wb bits
  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x, input logic [31:0] y,
                                          input int wa, input int wb);
    longint xa, yb, r;
    xa = longint'(x);
    yb = longint'(y);
    if (s) begin
      xa = (xa << (64 - wa)) >>> (64 - wa);
      yb = (yb << (64 - wb)) >>> (64 - wb);
    end
    r = xa * yb;
    return 64'(r) & ((64'd1 << (wa + wb)) - 64'd1);
  endfunction

  // drivers
  task automatic drive(input int which, input logic st, input logic s,
                       input logic [31:0] x, input logic [31:0] y);
    case (which)
      0:       begin start8  = st; sgn8  = s; a8  = x[7:0];  b8  = y[7:0]; end
      1:       begin start12 = st; sgn12 = s; a12 = x[11:0]; b12 = y[4:0]; end
      default: begin start13 = st; sgn13 = s; a13 = x[12:0]; b13 = y[6:0]; end
    endcase
  endtask

  // wait (bounded) for done; lat counts edges after the accept edge
  task automatic wait_done(input int which, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!sel_done(which) && lat < 60) begin
      bcnt += int'(sel_busy(which));
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input int which, input logic s, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] p, output int lat, output int bcnt);
    @(negedge clk);
    drive(which, 1'b1, s, x, y);
    @(negedge clk);
    drive(which, 1'b0, s, x, y);
    wait_done(which, lat, bcnt);
    p = sel_prod(which);
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] x, y;
    logic        s;
    int          lat, bcnt, seen;

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
    drive(2, 1'b0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_prod8", 64'(product8), 64'd0);
    check("rst_prod12", 64'(product12), 64'd0);
    check("rst_busy13", 64'(busy13), 64'd0);

    // 8x8 directed vectors
    run_op(0, 1'b0, 255, 255, p, lat, bcnt);
    check("u255x255", p, 64'hFE01);
    check("lat8", 64'(lat), 64'd9);
    check("busy_cycles8", 64'(bcnt), 64'd9);
    check("done_busy_low", 64'(busy8), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done8), 64'd0);

    run_op(0, 1'b1, 32'h80, 32'h80, p, lat, bcnt);
    check("s-128x-128", p, 64'h4000);
    run_op(0, 1'b1, 32'hFD, 32'h05, p, lat, bcnt);
    check("s-3x5", p, 64'hFFF1);
    run_op(0, 1'b1, 32'h07, 32'hFF, p, lat, bcnt);
    check("s7x-1", p, 64'hFFF9);
    run_op(0, 1'b1, 32'h80, 32'h7F, p, lat, bcnt);
    check("s-128x127", p, 64'hC080);
    run_op(0, 1'b0, 128, 2, p, lat, bcnt);
    check("u128x2", p, 64'h0100);
    run_op(0, 1'b0, 0, 255, p, lat, bcnt);
    check("u0x255", p, 64'h0000);

    // start pulsed during RUN is ignored and not queued
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 9, 9);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 9, 9);
    lat = 0;
    while (!done8 && lat < 60) begin
      if (lat == 2) drive(0, 1'b1, 1'b0, 1, 1);
      else          drive(0, 1'b0, 1'b0, 1, 1);
      @(negedge clk);
      lat++;
    end
    drive(0, 1'b0, 1'b0, 1, 1);
    check("run_start_prod", 64'(product8), 64'd81);
    check("run_start_lat", 64'(lat), 64'd9);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen |= int'(done8) | int'(busy8);
    end
    check("run_start_not_queued", 64'(seen), 64'd0);

    // start held in the done cycle: back-to-back accept
    run_op(0, 1'b0, 5, 7, p, lat, bcnt);
    check("b2b_first", p, 64'd35);
    drive(0, 1'b1, 1'b0, 2, 3);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 0, 0);
    check("b2b_no_gap", 64'(busy8), 64'd1);
    wait_done(0, lat, bcnt);
    check("b2b_lat", 64'(lat), 64'd9);
    check("b2b_second", 64'(product8), 64'd6);

    // reset at step 4 of 200x100 aborts
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 200, 100);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 200, 100);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_prod", 64'(product8), 64'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      seen |= int'(done8);
    end
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen |= int'(done8);
    end
    check("abort_no_done", 64'(seen), 64'd0);
    run_op(0, 1'b0, 10, 10, p, lat, bcnt);
    check("after_abort", p, 64'd100);

    // 12x5
    run_op(1, 1'b0, 4095, 31, p, lat, bcnt);
    check("u4095x31", p, 64'd126945);
    check("lat12", 64'(lat), 64'd6);
    run_op(1, 1'b1, 32'h800, 32'h10, p, lat, bcnt);
    check("s-2048x-16", p, 64'd32768);

    // random mixed-mode sweep at 8x8 and 13x7
    for (int i = 0; i < 300; i++) begin
      int which;
      which = (i % 2 == 0) ? 0 : 2;
      s = 1'($urandom_range(0, 1));
      x = $urandom & ((32'd1 << wa_of(which)) - 32'd1);
      y = $urandom & ((32'd1 << wb_of(which)) - 32'd1);
      run_op(which, s, x, y, p, lat, bcnt);
      check((which == 0) ? "rand8" : "rand13", p, ref_mul(s, x, y, wa_of(which), wb_of(which)));
      check((which == 0) ? "rand8_lat" : "rand13_lat", 64'(lat), 64'(wb_of(which) + 1));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
